// File: rtl/ddr4_cmd_monitor_u200.sv
// Passive DDR4 command-bus monitor: decodes each sampled command, tracks per-bank
// open/row/timer state, checks tRCD/tRP and basic protocol, and counts commands.

module ddr4_cmd_monitor_u200_bank (
   input  logic        clk,
   input  logic        sys_reset,
   input  logic        dram_rst,
   input  logic        act,
   input  logic        close,
   input  logic        pre_all,
   input  logic [16:0] row_in,
   output logic        is_open,
   output logic [16:0] row,
   output logic [3:0]  elapsed
);
   logic [3:0] tmr_q;

   // Edges since the last ACT/PRE, counting the current edge, saturating at 15.
   assign elapsed = (tmr_q == 4'hF) ? 4'hF : tmr_q + 4'd1;

   always_ff @(posedge clk) begin
      if (sys_reset) begin
         is_open <= 1'b0;
         row     <= '0;
         tmr_q   <= 4'hF;
      end else if (dram_rst) begin
         is_open <= 1'b0;
         tmr_q   <= 4'hF;
      end else begin
         tmr_q <= (act || close || pre_all) ? 4'd0 : elapsed;
         if (act) begin
            is_open <= 1'b1;
            row     <= row_in;
         end else if (close || pre_all) begin
            is_open <= 1'b0;
         end
      end
   end
endmodule

module ddr4_cmd_monitor_u200 #(
   parameter int TRCD_CK   = 14,
   parameter int TRP_CK    = 14,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 c0_ddr4_ck_t,
   input  logic                 sys_reset,
   input  logic                 c0_ddr4_reset_n,
   input  logic                 c0_ddr4_cke,
   input  logic                 c0_ddr4_cs_n,
   input  logic                 c0_ddr4_act_n,
   input  logic [16:0]          c0_ddr4_adr,
   input  logic [1:0]           c0_ddr4_ba,
   input  logic [1:0]           c0_ddr4_bg,
   output logic [CNT_WIDTH-1:0] cnt_act,
   output logic [CNT_WIDTH-1:0] cnt_rd,
   output logic [CNT_WIDTH-1:0] cnt_wr,
   output logic [CNT_WIDTH-1:0] cnt_pre,
   output logic [CNT_WIDTH-1:0] cnt_ref,
   output logic [CNT_WIDTH-1:0] cnt_mrs,
   output logic [CNT_WIDTH-1:0] cnt_zqc,
   output logic [15:0]          banks_open,
   output logic                 err_valid,
   output logic [2:0]           err_code,
   output logic [3:0]           err_bank,
   output logic [16:0]          err_row,
   output logic [15:0]          err_count,
   output logic                 err_sticky
);
   localparam int          NUM_BANKS = 16;
   localparam int          NUM_CNT   = 7;
   localparam logic [3:0]  TRCD_L    = 4'(TRCD_CK);
   localparam logic [3:0]  TRP_L     = 4'(TRP_CK);

   typedef enum logic [2:0] {
      OP_MRS = 3'b000, OP_REF = 3'b001, OP_PRE = 3'b010, OP_RSV = 3'b011,
      OP_WR  = 3'b100, OP_RD  = 3'b101, OP_ZQC = 3'b110, OP_NOP = 3'b111
   } op_e;

   typedef struct packed {
      logic zqc;
      logic mrs;
      logic refr;
      logic pre;
      logic wr;
      logic rd;
      logic act;
   } cmd_t;

   logic                             cmd_vld;
   op_e                              op;
   cmd_t                             cmd;
   logic [3:0]                       bank_idx;
   logic [NUM_BANKS-1:0]             sel;
   logic                             a10;
   logic                             rw;
   logic [NUM_BANKS-1:0]             bank_open;
   logic [NUM_BANKS-1:0][16:0]       bank_row;
   logic [NUM_BANKS-1:0][3:0]        bank_el;
   logic                             cur_open;
   logic [16:0]                      cur_row;
   logic [3:0]                       cur_el;
   logic                             err_hit;
   logic [2:0]                       err_nxt;
   logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_q;
   logic [NUM_CNT-1:0]               cnt_inc;

   assign cmd_vld  = !sys_reset && c0_ddr4_reset_n && c0_ddr4_cke && !c0_ddr4_cs_n;
   assign op       = op_e'(c0_ddr4_adr[16:14]);
   assign bank_idx = {c0_ddr4_bg, c0_ddr4_ba};
   assign sel      = 16'h0001 << bank_idx;
   assign a10      = c0_ddr4_adr[10];

   always_comb begin
      cmd = '0;
      if (cmd_vld) begin
         if (!c0_ddr4_act_n) begin
            cmd.act = 1'b1;
         end else begin
            case (op)
               OP_MRS:  cmd.mrs  = 1'b1;
               OP_REF:  cmd.refr = 1'b1;
               OP_PRE:  cmd.pre  = 1'b1;
               OP_WR:   cmd.wr   = 1'b1;
               OP_RD:   cmd.rd   = 1'b1;
               OP_ZQC:  cmd.zqc  = 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign rw      = cmd.rd || cmd.wr;
   assign cnt_inc = cmd;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      ddr4_cmd_monitor_u200_bank u_bank (
         .clk       (c0_ddr4_ck_t),
         .sys_reset (sys_reset),
         .dram_rst  (!c0_ddr4_reset_n),
         .act       (cmd.act && sel[b]),
         .close     (sel[b] && ((cmd.pre && !a10) || (rw && a10))),
         .pre_all   (cmd.pre && a10),
         .row_in    (c0_ddr4_adr),
         .is_open   (bank_open[b]),
         .row       (bank_row[b]),
         .elapsed   (bank_el[b])
      );
   end

   assign cur_open = bank_open[bank_idx];
   assign cur_row  = bank_row[bank_idx];
   assign cur_el   = bank_el[bank_idx];

   // Checks run in code order so the lowest violation code wins.
   always_comb begin
      err_hit = 1'b1;
      err_nxt = 3'd0;
      if (rw && !cur_open)                   err_nxt = 3'd1;
      else if (cmd.act && cur_open)          err_nxt = 3'd2;
      else if (rw && cur_el < TRCD_L)        err_nxt = 3'd3;
      else if (cmd.act && cur_el < TRP_L)    err_nxt = 3'd4;
      else if (cmd.refr && |bank_open)       err_nxt = 3'd5;
      else                                   err_hit = 1'b0;
   end

   always_ff @(posedge c0_ddr4_ck_t) begin
      if (sys_reset) begin
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++)
            if (cnt_inc[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge c0_ddr4_ck_t) begin
      if (sys_reset) begin
         err_valid  <= 1'b0;
         err_code   <= '0;
         err_bank   <= '0;
         err_row    <= '0;
         err_count  <= '0;
         err_sticky <= 1'b0;
      end else begin
         err_valid <= err_hit;
         if (err_hit) begin
            err_code   <= err_nxt;
            err_bank   <= bank_idx;
            err_row    <= cur_row;
            err_sticky <= 1'b1;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         end
      end
   end

   assign cnt_act    = cnt_q[0];
   assign cnt_rd     = cnt_q[1];
   assign cnt_wr     = cnt_q[2];
   assign cnt_pre    = cnt_q[3];
   assign cnt_ref    = cnt_q[4];
   assign cnt_mrs    = cnt_q[5];
   assign cnt_zqc    = cnt_q[6];
   assign banks_open = bank_open;
endmodule

// File: doc/ddr4_cmd_monitor_u200.md
# ddr4_cmd_monitor_u200

Simulation-only DDR4 command-bus monitor for the U200 single-rank RDIMM. It sits on the `c0_ddr4_*` pin bundle between the memory controller and the DIMM model, in parallel with the model, and listens only. Each clock it decodes one command and tracks open/closed state and the open row for all 16 banks. It checks basic protocol and tRCD/tRP spacing, and exposes command counters plus an error stream for the testbench scoreboard.

## Interface
Parameters:
- `TRCD_CK`, 14: minimum clocks from ACT to RD/WR on the same bank.
- `TRP_CK`, 14: minimum clocks from PRE (explicit or auto) to ACT on the same bank.
- `CNT_WIDTH`, 32: width of each command counter.

Ports (one clock; reset is synchronous and active-high):
- `c0_ddr4_ck_t`  in  1  sampling clock; all state is updated on its rising edge.
- `sys_reset`  in  1  synchronous, active-high reset.
- `c0_ddr4_reset_n`  in  1  DRAM reset.
- `c0_ddr4_cke`  in  1  clock enable.
- `c0_ddr4_cs_n`  in  1  chip select, active low.
- `c0_ddr4_act_n`  in  1  activate, active low.
- `c0_ddr4_adr`  in  17  address; bits [16:14] carry RAS_n, CAS_n and WE_n when `act_n`=1.
- `c0_ddr4_ba`  in  2  bank address.
- `c0_ddr4_bg`  in  2  bank group.
- `cnt_act`, `cnt_rd`, `cnt_wr`, `cnt_pre`, `cnt_ref`, `cnt_mrs`, `cnt_zqc`  out  CNT_WIDTH each  command counters; they saturate at the maximum value.
- `banks_open`  out  16  per-bank open flag, indexed by {bg, ba}.
- `err_valid`  out  1  one-cycle pulse per detected violation.
- `err_code`  out  3  violation code; held until the next error.
- `err_bank`  out  4  {bg, ba} of the offending command.
- `err_row`  out  17  row address of the bank at the time of the violation.
- `err_count`  out  16  total violations; saturates.
- `err_sticky`  out  1  set on the first violation, cleared only by reset.

## Operation
- **Command valid:** `sys_reset`=0, `c0_ddr4_reset_n`=1, `cke`=1 and `cs_n`=0. Every other cycle is a deselect and has no effect.
- **Decode:**
  - `act_n`=0: ACT. Row = `adr[16:0]`.
  - `act_n`=1: the code {adr[16], adr[15], adr[14]} selects the command:
    - 000 MRS
    - 001 REF
    - 010 PRE
    - 100 WR
    - 101 RD
    - 110 ZQC
    - 111 NOP
    - 011 is reserved: ignored, not counted.
- **Bank state:** each bank holds an open flag, a 17-bit row, and a 4-bit elapsed-cycle timer.
  - The timer saturates at 15.
  - The timer loads 0 on ACT, PRE, or auto-precharge to that bank, and increments every other cycle.
- **Command effects:**
  - ACT: opens the bank and records the row.
  - PRE: `adr[10]`=0 closes the addressed bank; `adr[10]`=1 closes all banks and resets every bank's timer. Precharging a closed bank is legal and restarts that bank's timer.
  - RD/WR with `adr[10]`=1 (auto-precharge): the bank closes in the same update and its timer restarts.
- **Violation codes:**
  - 1: RD/WR to a closed bank.
  - 2: ACT to an open bank.
  - 3: RD/WR with timer < TRCD_CK.
  - 4: ACT with timer < TRP_CK.
  - 5: REF while any bank is open.
- **Error priority:** at most one error per cycle; the lowest code wins.
- **Illegal commands still update state:** an ACT to an open bank overwrites the row; an RD/WR to a closed bank leaves the bank closed.
- **Counters:** incremented for every decoded command, legal or not.
- **DRAM reset:** when `c0_ddr4_reset_n`=0, all banks close and all timers set to 15; counters and error state are preserved.

## Timing
- All outputs are registered; each reflects the command sampled on edge N at edge N+1.
- **Reset values:** all counters 0, `banks_open`=0, `err_*` all 0, timers 15.
- `sys_reset` asserted in the middle of traffic clears everything on the next edge, and the command on that edge is ignored.
- The timer counts edges since the ACT: an RD issued k edges after the ACT sees timer=k. It violates when k < TRCD_CK, so k = TRCD_CK is legal.
- `err_valid` is a single-cycle pulse. Back-to-back violations give consecutive pulses, and `err_count` advances by one each.

## Test plan
- **Clean traffic:** ACT bg1/ba2 row 0x1ABC; RD 14 cycles later; PRE 20 cycles later. Required: `banks_open[6]` goes 1 then 0; `cnt_act`=`cnt_rd`=`cnt_pre`=1; `err_sticky`=0.
- **tRCD violation:** ACT bank 0, then RD 13 cycles later. Required: `err_valid` pulse, `err_code`=3, `err_bank`=0, `err_row`=row of bank 0, `err_count`=1.
- **Closed bank, auto-precharge, tRP:** RD bank 5 with no ACT gives code 1. Then ACT bank 5, WR with A10=1 after 14 cycles, ACT bank 5 again 10 cycles later. Required: code 4 on the second ACT; `banks_open[5]`=1 afterwards.
- **PRE-all and REF:** open banks 0, 3 and 15, then REF. Required: code 5. Then PRE with A10=1, wait 14 cycles, REF. Required: no error; `banks_open`=0; `cnt_ref`=2.
- **Resets:** deselect cycles (`cs_n`=1) with RD encoding give no count change. Drop `c0_ddr4_reset_n` with banks open: `banks_open` clears and counters keep their values. Assert `sys_reset` in the middle of traffic: all outputs are 0 on the next edge.
- **Saturation:** force `cnt_rd` and `err_count` near their maximums (CNT_WIDTH=4 build for `cnt_rd`) and issue more commands and errors. Required: `cnt_rd` holds at 0xF and `err_count` holds at 0xFFFF.
